// File: rtl/flash_spi_pkg.sv
// Shared constants and state encoding for the on-chip SPI flash reader.
package flash_spi_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         CMD_BITS       = 8;
    localparam int         ADDR_BITS      = 24;
    localparam int         ADDR_BYTES     = ADDR_BITS / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_STALL,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/spi_byte_engine.sv
// SCK divider plus 8-bit MSB-first shifter, SPI mode 0; one byte per start.
// A start on the byte_done cycle chains the next byte with no gap on SCK.
module spi_byte_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic             active_q, active_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= 3'd0;
            sh_q     <= 8'h00;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
        end
    end

    always_comb begin
        active_d  = active_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        tick      = (div_q == DIV_W'(CLK_DIV - 1));
        byte_done = active_q && sck_q && tick && (bit_q == 3'd0);

        if (active_q) begin
            if (tick) begin
                div_d = '0;
                if (!sck_q) begin
                    // Rising edge: sample MISO; the shifter fills with rx as tx drains
                    sck_d = 1'b1;
                    sh_d  = {sh_q[6:0], miso};
                end else begin
                    sck_d = 1'b0;
                    if (bit_q == 3'd0) begin
                        active_d = 1'b0;
                        mosi_d   = 1'b0;
                    end else begin
                        bit_d  = bit_q - 3'd1;
                        mosi_d = sh_q[7];
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        if (start && (!active_q || byte_done)) begin
            active_d = 1'b1;
            sh_d     = tx_byte;
            mosi_d   = tx_byte[7];
            sck_d    = 1'b0;
            div_d    = '0;
            bit_d    = 3'd7;
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign rx_byte = sh_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Autonomous 25-series flash reader: READ 0x03 + 24-bit address, then LEN bytes out.
// A full output register stalls SCK low with CS held; the pending byte waits in the shifter.
module spi_flash_reader
    import flash_spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16,
    parameter int CS_HOLD = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [23:0]      ADDR,
    input  logic [LEN_W-1:0] LEN,
    output logic             BUSY,
    output logic             DONE,
    output logic [7:0]       DATA,
    output logic             DATA_VALID,
    input  logic             DATA_READY,
    output logic             FLASH_CS_n,
    output logic             FLASH_CLK,
    output logic             FLASH_DI,
    input  logic             FLASH_DO
);

    localparam int HOLD_W = $clog2(CS_HOLD + 1);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       addr_q, addr_d;
    logic [1:0]        abyte_q, abyte_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              done_q, done_d;
    logic              cs_n_q, cs_n_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;

    logic              eng_start;
    logic [7:0]        eng_tx;
    logic              eng_done;
    logic [7:0]        eng_rx;
    logic              out_free;
    logic              load_byte;

    spi_byte_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk       (CLK),
        .rst       (RESET),
        .start     (eng_start),
        .tx_byte   (eng_tx),
        .miso      (FLASH_DO),
        .sck       (FLASH_CLK),
        .mosi      (FLASH_DI),
        .byte_done (eng_done),
        .rx_byte   (eng_rx)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= 24'h000000;
            abyte_q <= 2'd0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            abyte_q <= abyte_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            cs_n_q  <= cs_n_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        abyte_d   = abyte_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        cs_n_d    = cs_n_q;
        eng_start = 1'b0;
        eng_tx    = 8'h00;
        load_byte = 1'b0;
        out_free  = !valid_q || DATA_READY;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (LEN == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d     = LEN;
                        addr_d    = ADDR;
                        cs_n_d    = 1'b0;
                        eng_start = 1'b1;
                        eng_tx    = FLASH_CMD_READ;
                        state_d   = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (eng_done) begin
                    eng_start = 1'b1;
                    eng_tx    = addr_q[23:16];
                    addr_d    = {addr_q[15:0], 8'h00};
                    abyte_d   = 2'd0;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (eng_done) begin
                    eng_start = 1'b1;
                    if (abyte_q == 2'(ADDR_BYTES - 1)) begin
                        state_d = ST_DATA;
                    end else begin
                        eng_tx  = addr_q[23:16];
                        addr_d  = {addr_q[15:0], 8'h00};
                        abyte_d = abyte_q + 2'd1;
                    end
                end
            end
            ST_DATA, ST_STALL: begin
                if (state_q == ST_STALL || eng_done) begin
                    if (out_free) begin
                        load_byte = 1'b1;
                        cnt_d     = cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            cs_n_d  = 1'b1;
                            hold_d  = '0;
                            state_d = ST_FINISH;
                        end else begin
                            eng_start = 1'b1;
                            state_d   = ST_DATA;
                        end
                    end else begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_FINISH: begin
                if (hold_q == HOLD_W'(CS_HOLD - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output register drains independently of the sequencer state
        data_d  = data_q;
        valid_d = valid_q;
        if (load_byte) begin
            data_d  = eng_rx;
            valid_d = 1'b1;
        end else if (valid_q && DATA_READY) begin
            valid_d = 1'b0;
        end
    end

    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = done_q;
    assign DATA       = data_q;
    assign DATA_VALID = valid_q;
    assign FLASH_CS_n = cs_n_q;

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- On-chip SPI master that reads the configuration flash (25-series, READ opcode 0x03) without an external host.
- It is the initiator end of the flash SPI link that the existing bridge otherwise hands to an external master.
- It issues command plus 24-bit address, then streams LEN bytes out through a valid/ready byte interface.
- Sits between the flash pins (through the pin mux) and on-chip consumers such as a ROM/RAM preloader.

Parameters:
- CLK_DIV, 2, SCK half-period in CLK cycles (>=1); one SPI bit = 2*CLK_DIV CLK cycles.
- LEN_W, 16, width of the byte-count input.
- CS_HOLD, 4, minimum CLK cycles FLASH_CS_n stays high after a transfer (>=1).

Ports:
- CLK  in  1  global clock, 48 MHz.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- ADDR  in  24  flash start byte address; latched on accepted START.
- LEN  in  LEN_W  bytes to read; latched on accepted START; 0 = no bus activity.
- BUSY  out  1  high from the cycle after an accepted START until return to IDLE.
- DONE  out  1  one-cycle pulse at transfer completion.
- DATA  out  8  read byte.
- DATA_VALID  out  1  DATA holds an unconsumed byte.
- DATA_READY  in  1  consumer accepts DATA when DATA_VALID & DATA_READY.
- FLASH_CS_n  out  1  flash chip select, active low.
- FLASH_CLK  out  1  SCK, SPI mode 0 (idle low).
- FLASH_DI  out  1  MOSI to flash.
- FLASH_DO  in  1  MISO from flash.

Behaviour:
- Reset values: FLASH_CS_n=1, FLASH_CLK=0, FLASH_DI=0, BUSY=0, DONE=0, DATA=0, DATA_VALID=0, state IDLE. Async assertion mid-transfer aborts immediately to these values.
- States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DATA -> STALL <-> DATA -> FINISH -> IDLE.
- IDLE:
  - START with LEN!=0: the next cycle drives CS_n=0, enters CMD, and drives DI=opcode bit7.
  - START with LEN=0: DONE pulses the next cycle; no CS activity; BUSY stays 0.
  - START while not in IDLE is ignored.
- Bit timing:
  - SCK is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - DI changes only while SCK is low, on entry to each low phase. Bits are MSB first.
  - FLASH_DO is sampled on the CLK where SCK rises.
  - The first rising edge occurs CLK_DIV cycles after CS_n falls.
- CMD shifts 0x03. ADDR shifts ADDR[23:0]. DI=0 during DATA.
- DATA: after 8 samples the byte is complete.
  - If the output register is empty, or is being consumed this cycle, the byte moves into DATA, DATA_VALID=1, and the remaining count decrements.
  - Otherwise go to STALL: SCK held low, CS_n held low, the byte held in the shift register.
  - STALL transfers the byte on the first cycle the output frees, then resumes.
  - The next byte's low phase starts the cycle after the transfer.
- Data path limits: at most 1 byte in the shift register plus 1 in DATA; no bytes are dropped or duplicated.
- FINISH: entered after the last byte is transferred to DATA.
  - SCK ends low and CS_n goes high on FINISH entry.
  - CS_n is held high CS_HOLD cycles, then DONE pulses for one cycle, BUSY falls, and the block returns to IDLE.
  - DATA_VALID may still be high at DONE; it clears on consumption independently of state.
- Remaining count is LEN_W bits, loaded with LEN. Completion occurs when it reaches 0; it never wraps.
- Address is not incremented internally; the flash auto-increments. The 24-bit address wraps at the flash's end per the flash device.
- DATA_READY asserted without DATA_VALID has no effect. DATA is stable while DATA_VALID & !DATA_READY.

Decomposition:
- Package flash_spi_pkg:
  - FLASH_CMD_READ = 8'h03.
  - state enum {IDLE, CMD, ADDR, DATA, STALL, FINISH}.
  - CMD_BITS = 8, ADDR_BITS = 24.
- One sub-module, spi_byte_engine: SCK divider plus an 8-bit MSB-first shift in/out with start/done handshake.
- The top-level FSM sequences 1 command byte, 3 address bytes, and N data bytes through the engine.

Test Plan:
- CLK_DIV=2, START with ADDR=24'h012345, LEN=1, flash model returns 8'hA5, DATA_READY=1:
  - MOSI shows 0x03,0x01,0x23,0x45.
  - SCK period is 4 CLK cycles, with exactly 40 rising edges.
  - DATA=8'hA5 with DATA_VALID pulse.
  - CS_n high CS_HOLD cycles, then DONE pulse.
- LEN=4, flash returns 0x10..0x13, DATA_READY tied low until the 2nd byte completes:
  - SCK stops low, CS_n stays low in STALL.
  - After DATA_READY=1, bytes are received in order 10,11,12,13 with no loss.
- LEN=0 START -> DONE one cycle later; CS_n, SCK, and BUSY never toggle.
- RESET asserted mid-ADDR phase:
  - Same cycle, CS_n=1, SCK=0, BUSY=0, DATA_VALID=0.
  - A new START then produces a clean 0x03 command.
- START pulsed while BUSY:
  - Ignored; transfer count and address unchanged.
  - Exactly LEN bytes delivered, then one DONE.
- CLK_DIV=1, LEN=16'hFFFF, DATA_READY=1: 65535 bytes delivered, counter reaches 0 without wrap, single DONE.
